// File: rtl/axis_pkg.sv
// Shared types and helpers for the AXI-Stream packet validator.
package axis_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam int STAT_W = 16;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/axis_register.sv
// 1-deep output register with a skid slot: full throughput, registered ready.
module axis_register #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         live;
  logic         skid_vld;
  logic [W-1:0] skid_data;
  logic         in_fire;

  // live keeps ready low while in reset and for the release edge.
  assign in_ready = live && !skid_vld;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      live      <= 1'b0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      live <= 1'b1;
      if (out_ready || !out_valid) begin
        if (skid_vld) begin
          out_valid <= 1'b1;
          out_data  <= skid_data;
          skid_vld  <= 1'b0;
        end else begin
          out_valid <= in_fire;
          if (in_fire) out_data <= in_data;
        end
      end else if (in_fire) begin
        skid_vld  <= 1'b1;
        skid_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axis_packet_validator.sv
// Checks packet length on an AXI-Stream: flags runts, truncates oversize packets.
module axis_packet_validator
  import axis_pkg::*;
#(
  parameter int AXIS_BYTES     = 1,
  parameter int AXIS_USER_BITS = 1,
  parameter int MIN_BEATS      = 4,
  parameter int MAX_BEATS      = 1500
) (
  input  logic                      clk,
  input  logic                      aresetn,
  output logic                      axis_i_tready,
  input  logic                      axis_i_tvalid,
  input  logic                      axis_i_tlast,
  input  logic [AXIS_BYTES*8-1:0]   axis_i_tdata,
  input  logic [AXIS_USER_BITS-1:0] axis_i_tuser,
  input  logic                      axis_o_tready,
  output logic                      axis_o_tvalid,
  output logic                      axis_o_tlast,
  output logic [AXIS_BYTES*8-1:0]   axis_o_tdata,
  output logic [AXIS_USER_BITS-1:0] axis_o_tuser,
  output logic                      axis_o_error,
  output logic [15:0]               runt_count,
  output logic [15:0]               oversize_count
);

  localparam int CW = $clog2(MAX_BEATS + 2);
  localparam int DW = AXIS_BYTES * 8;
  localparam int PW = DW + AXIS_USER_BITS + 2;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, beat_num;
  logic            reg_in_valid, reg_in_ready;
  logic            fire, runt, oversize;
  logic [PW-1:0]   in_pl, out_pl;
  logic [15:0]     runt_q, ovs_q;

  assign axis_i_tready = (state_q == DISCARD) ? 1'b1 : reg_in_ready;
  assign fire          = axis_i_tvalid && axis_i_tready;
  assign beat_num      = cnt_q + CW'(1);
  assign runt          = (state_q != DISCARD) && axis_i_tlast && (beat_num < CW'(MIN_BEATS));
  assign oversize      = (state_q == IN_PKT) && (beat_num == CW'(MAX_BEATS + 1));

  // Discarded beats never reach the output register.
  assign reg_in_valid = axis_i_tvalid && (state_q != DISCARD);
  assign in_pl        = {axis_i_tdata, axis_i_tuser, axis_i_tlast || oversize, runt || oversize};

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (fire) begin
      unique case (state_q)
        IDLE: begin
          state_d = axis_i_tlast ? IDLE : IN_PKT;
          cnt_d   = axis_i_tlast ? '0 : beat_num;
        end
        IN_PKT: begin
          if (oversize) begin
            state_d = axis_i_tlast ? IDLE : DISCARD;
            cnt_d   = '0;
          end else if (axis_i_tlast) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = beat_num;
          end
        end
        DISCARD: begin
          if (axis_i_tlast) state_d = IDLE;
          cnt_d = '0;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      runt_q <= '0;
      ovs_q  <= '0;
    end else if (fire && state_q != DISCARD) begin
      if (runt)     runt_q <= sat_inc(runt_q);
      if (oversize) ovs_q  <= sat_inc(ovs_q);
    end
  end

  assign runt_count     = runt_q;
  assign oversize_count = ovs_q;

  axis_register #(.W(PW)) u_out (
    .clk       (clk),
    .aresetn   (aresetn),
    .in_valid  (reg_in_valid),
    .in_ready  (reg_in_ready),
    .in_data   (in_pl),
    .out_valid (axis_o_tvalid),
    .out_ready (axis_o_tready),
    .out_data  (out_pl)
  );

  assign {axis_o_tdata, axis_o_tuser, axis_o_tlast, axis_o_error} = out_pl;

endmodule
